// File: rtl/spi_pkg.sv
// spi_pkg: state encodings and the select-width helper shared by the
// SPI transaction arbiter and its round-robin sub-block.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } spi_state_e;

    // Width of a slave index; a single requester still needs one bit.
    function automatic int spi_sel_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin pick. The search starts at
// ptr and wraps, so the requester at ptr has the highest priority.
module spi_rr_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int SEL_W = spi_sel_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    // First active request at or after ptr (with wrap) wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = SEL_W'(idx);
                grant_valid = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one SPI phy among N_REQ requesters. Each grant
// runs a whole multi-byte transaction (IDLE -> XFER -> DRAIN -> GAP).
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort stalled transfers
// after TIMEOUT_CYCLES quiet cycles; otherwise err is tied low.
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int LEN_W          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int SEL_W = spi_sel_w(N_REQ)
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic [N_REQ*8-1:0]     tx_data,
    output logic [N_REQ-1:0]       tx_ack,
    output logic [7:0]             rx_data,
    output logic [N_REQ-1:0]       rx_valid,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       err,
    output logic                   busy,
    output logic                   phy_enable,
    output logic [7:0]             phy_byte_in,
    output logic [SEL_W-1:0]       phy_sel,
    input  logic                   phy_byte_written,
    input  logic [7:0]             phy_byte_out,
    input  logic                   phy_byte_valid
);

    // One extra bit so a length of 2^LEN_W is represented exactly.
    localparam int CNT_W = LEN_W + 1;

    spi_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d;
    logic             en_q, en_d, busy_q, busy_d;
    logic [7:0]       byte_in_q, byte_in_d, rx_data_q, rx_data_d;
    logic [N_REQ-1:0] tx_ack_q, tx_ack_d, rx_valid_q, rx_valid_d, done_q, done_d;
    logic [CNT_W-1:0] len_q, len_d, sent_q, sent_d, rcvd_q, rcvd_d;
    logic [15:0]      gap_q, gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [N_REQ-1:0] err_q, err_d;
    logic [31:0]      wdog_q, wdog_d;
`endif

    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_valid;

    spi_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req         (req),
        .ptr         (ptr_q),
        .grant       (gnt),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_valid)
    );

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [N_REQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [SEL_W-1:0] i);
        return tx_data[int'(i)*8 +: 8];
    endfunction

    // A zero length field means the full 2^LEN_W bytes.
    function automatic logic [CNT_W-1:0] pick_len(input logic [SEL_W-1:0] i);
        logic [LEN_W-1:0] raw;
        raw = req_len[int'(i)*LEN_W +: LEN_W];
        if (raw == '0) begin
            return {1'b1, {LEN_W{1'b0}}};
        end else begin
            return {1'b0, raw};
        end
    endfunction

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        en_d       = en_q;
        byte_in_d  = byte_in_q;
        rx_data_d  = rx_data_q;
        tx_ack_d   = '0;
        rx_valid_d = '0;
        done_d     = '0;
        len_d      = len_q;
        sent_d     = sent_q;
        rcvd_d     = rcvd_q;
        gap_d      = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
        err_d      = '0;
        wdog_d     = wdog_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d   = ST_XFER;
                    sel_d     = gnt_idx;
                    en_d      = 1'b1;
                    byte_in_d = pick_byte(gnt_idx);
                    tx_ack_d  = gnt;
                    len_d     = pick_len(gnt_idx);
                    sent_d    = CNT_W'(1);
                    rcvd_d    = '0;
                    ptr_d     = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + SEL_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER, ST_DRAIN: begin
                if ((state_q == ST_XFER) && phy_byte_written) begin
                    if (sent_q < len_q) begin
                        byte_in_d = pick_byte(sel_q);
                        tx_ack_d  = onehot(sel_q);
                        sent_d    = sent_q + CNT_W'(1);
                    end else begin
                        en_d    = 1'b0;
                        state_d = ST_DRAIN;
                    end
                end else begin
                    sent_d = sent_q;
                end
                if (phy_byte_valid) begin
                    rx_data_d  = phy_byte_out;
                    rx_valid_d = onehot(sel_q);
                    rcvd_d     = rcvd_q + CNT_W'(1);
                    if ((rcvd_q + CNT_W'(1)) == len_q) begin
                        done_d  = onehot(sel_q);
                        en_d    = 1'b0;
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else begin
                        done_d = '0;
                    end
                end else begin
                    rcvd_d = rcvd_q;
                end
            end
            ST_GAP: begin
                if ((int'(gap_q) + 32'sd1) >= GAP_CYCLES) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        endcase
`ifdef SPI_ARB_TIMEOUT_EN
        if ((state_q == ST_XFER) || (state_q == ST_DRAIN)) begin
            if (phy_byte_written || phy_byte_valid) begin
                wdog_d = '0;
            end else if (wdog_q == 32'(TIMEOUT_CYCLES - 1)) begin
                err_d   = onehot(sel_q);
                en_d    = 1'b0;
                state_d = ST_GAP;
                gap_d   = '0;
                wdog_d  = '0;
            end else begin
                wdog_d = wdog_q + 32'd1;
            end
        end else begin
            wdog_d = '0;
        end
`endif
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous reset clears everything.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            ptr_q      <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            byte_in_q  <= 8'd0;
            rx_data_q  <= 8'd0;
            tx_ack_q   <= '0;
            rx_valid_q <= '0;
            done_q     <= '0;
            len_q      <= '0;
            sent_q     <= '0;
            rcvd_q     <= '0;
            gap_q      <= 16'd0;
`ifdef SPI_ARB_TIMEOUT_EN
            err_q      <= '0;
            wdog_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            byte_in_q  <= byte_in_d;
            rx_data_q  <= rx_data_d;
            tx_ack_q   <= tx_ack_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            len_q      <= len_d;
            sent_q     <= sent_d;
            rcvd_q     <= rcvd_d;
            gap_q      <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
            err_q      <= err_d;
            wdog_q     <= wdog_d;
`endif
        end
    end

    assign tx_ack      = tx_ack_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign phy_enable  = en_q;
    assign phy_byte_in = byte_in_q;
    assign phy_sel     = sel_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign err         = err_q;
`else
    assign err         = '0;
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed steps with hand-computed expectations.
// The bench plays the requesters and the phy, driving inputs just after
// each rising edge and sampling registered outputs 1 time unit later.
module tb_spi_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  req_len;
    logic [15:0] tx_data;
    logic [1:0]  tx_ack, rx_valid, done, err;
    logic [7:0]  rx_data, phy_byte_in, phy_bo;
    logic        busy, phy_enable, phy_bw, phy_bv;
    logic [0:0]  phy_sel;

    int n_cmp = 0;
    int n_err = 0;
    int n_ack, n_rx, n_early_done;

    spi_txn_arbiter #(
        .N_REQ(2), .LEN_W(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(32)
    ) dut (
        .clk_in(clk), .reset(rst), .req(req), .req_len(req_len), .tx_data(tx_data),
        .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
        .err(err), .busy(busy), .phy_enable(phy_enable), .phy_byte_in(phy_byte_in),
        .phy_sel(phy_sel), .phy_byte_written(phy_bw), .phy_byte_out(phy_bo),
        .phy_byte_valid(phy_bv)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_tx_ack"},   32'(tx_ack),      32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid),    32'd0);
        chk({tag, "_done"},     32'(done),        32'd0);
        chk({tag, "_err"},      32'(err),         32'd0);
        chk({tag, "_busy"},     32'(busy),        32'd0);
        chk({tag, "_en"},       32'(phy_enable),  32'd0);
        chk({tag, "_byte_in"},  32'(phy_byte_in), 32'd0);
        chk({tag, "_sel"},      32'(phy_sel),     32'd0);
        chk({tag, "_rx_data"},  32'(rx_data),     32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 2'b11; req_len = 8'h11; tx_data = 16'h0000;
        phy_bw = 1'b0; phy_bv = 1'b0; phy_bo = 8'h00;
        step();
        step();
        chk_idle_outputs("reset");

        // Round robin with both requesters held: 0,1,0,1, len=1 each.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_sel",    32'(phy_sel), 32'(k % 2));
            chk("rr_ack",    32'(tx_ack),  32'(1 << (k % 2)));
            chk("rr_en",     32'(phy_enable), 32'd1);
            phy_bw = 1'b1; step(); phy_bw = 1'b0;
            chk("rr_drain_en", 32'(phy_enable), 32'd0);
            phy_bv = 1'b1; phy_bo = 8'(k); step(); phy_bv = 1'b0;
            chk("rr_done",   32'(done),     32'(1 << (k % 2)));
            chk("rr_rxv",    32'(rx_valid), 32'(1 << (k % 2)));
            step(); step();
            chk("rr_idle_busy", 32'(busy), 32'd0);
        end
        req = 2'b00;

        // Requester 0, three bytes, phy echoes each byte back.
        req_len = 8'h03; tx_data = 16'h0055; req = 2'b01; step();
        chk("t1_ack0", 32'(tx_ack), 32'd1);
        chk("t1_en", 32'(phy_enable), 32'd1);
        chk("t1_b0", 32'(phy_byte_in), 32'h55);
        chk("t1_sel", 32'(phy_sel), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        req = 2'b00; tx_data = 16'h00AA; phy_bw = 1'b1; step();
        chk("t1_ack1", 32'(tx_ack), 32'd1);
        chk("t1_b1", 32'(phy_byte_in), 32'hAA);
        chk("t1_norx", 32'(rx_valid), 32'd0);
        tx_data = 16'h000F; phy_bv = 1'b1; phy_bo = 8'h55; step();
        chk("t1_ack2", 32'(tx_ack), 32'd1);
        chk("t1_b2", 32'(phy_byte_in), 32'h0F);
        chk("t1_rxv0", 32'(rx_valid), 32'd1);
        chk("t1_rx0", 32'(rx_data), 32'h55);
        phy_bo = 8'hAA; step();
        chk("t1_drain_en", 32'(phy_enable), 32'd0);
        chk("t1_no_ack", 32'(tx_ack), 32'd0);
        chk("t1_rx1", 32'(rx_data), 32'hAA);
        chk("t1_nodone", 32'(done), 32'd0);
        phy_bw = 1'b0; phy_bo = 8'h0F; step();
        chk("t1_rxv2", 32'(rx_valid), 32'd1);
        chk("t1_rx2", 32'(rx_data), 32'h0F);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_gap_busy", 32'(busy), 32'd1);
        phy_bw = 1'b1; phy_bv = 1'b1; phy_bo = 8'hEE; step();
        chk("t1_gap_ign_rxv", 32'(rx_valid), 32'd0);
        chk("t1_gap_ign_rx", 32'(rx_data), 32'h0F);
        chk("t1_gap_done0", 32'(done), 32'd0);
        chk("t1_gap2_busy", 32'(busy), 32'd1);
        chk("t1_gap_en", 32'(phy_enable), 32'd0);
        phy_bw = 1'b0; phy_bv = 1'b0; step();
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Requester 1, length field 0 -> 16 bytes.
        req_len = 8'h00; tx_data = 16'h0000; req = 2'b10; step();
        chk("t16_sel", 32'(phy_sel), 32'd1);
        n_ack = (tx_ack == 2'b10) ? 1 : 0;
        n_rx = 0; n_early_done = 0;
        req = 2'b00;
        for (int i = 1; i < 16; i++) begin
            tx_data = 16'(i << 8); phy_bw = 1'b1; phy_bv = 1'b1; phy_bo = 8'(i); step();
            if (tx_ack == 2'b10) n_ack++;
            if (rx_valid == 2'b10) n_rx++;
            if (done != 2'b00) n_early_done++;
        end
        phy_bo = 8'hF0; step();
        if (rx_valid == 2'b10) n_rx++;
        phy_bw = 1'b0; phy_bv = 1'b0;
        chk("t16_done", 32'(done), 32'd2);
        chk("t16_rx", 32'(rx_data), 32'hF0);
        chk("t16_acks", 32'(n_ack), 32'd16);
        chk("t16_rxvs", 32'(n_rx), 32'd16);
        chk("t16_early_done", 32'(n_early_done), 32'd0);
        chk("t16_en", 32'(phy_enable), 32'd0);
        step(); step();

        // Simultaneous written/valid, len=2 on requester 0.
        req_len = 8'h02; tx_data = 16'h0033; req = 2'b01; step();
        chk("t2_ack0", 32'(tx_ack), 32'd1);
        req = 2'b00; tx_data = 16'h0044; phy_bw = 1'b1; phy_bv = 1'b1; phy_bo = 8'h33; step();
        chk("t2_ack1", 32'(tx_ack), 32'd1);
        chk("t2_b1", 32'(phy_byte_in), 32'h44);
        chk("t2_rxv0", 32'(rx_valid), 32'd1);
        chk("t2_nodone", 32'(done), 32'd0);
        phy_bo = 8'h44; step();
        phy_bw = 1'b0; phy_bv = 1'b0;
        chk("t2_rxv1", 32'(rx_valid), 32'd1);
        chk("t2_rx1", 32'(rx_data), 32'h44);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_en", 32'(phy_enable), 32'd0);
        step(); step();
        chk("t2_idle", 32'(busy), 32'd0);

        // Reset in XFER after byte 2 of 4, then a fresh grant to index 0.
        req_len = 8'h04; tx_data = 16'h0011; req = 2'b01; step();
        req = 2'b00; tx_data = 16'h0022; phy_bw = 1'b1; step();
        chk("t3_b1", 32'(phy_byte_in), 32'h22);
        phy_bw = 1'b0; rst = 1'b1; step();
        chk_idle_outputs("t3_rst");
        rst = 1'b0; req_len = 8'h11; tx_data = 16'h6655; req = 2'b11; step();
        req = 2'b00;
        chk("t3_sel", 32'(phy_sel), 32'd0);
        chk("t3_ack", 32'(tx_ack), 32'd1);
        chk("t3_b0", 32'(phy_byte_in), 32'h55);
        phy_bw = 1'b1; step(); phy_bw = 1'b0;
        phy_bv = 1'b1; phy_bo = 8'h55; step(); phy_bv = 1'b0;
        chk("t3_done", 32'(done), 32'd1);
        step(); step();

        // Phy stalls after the first byte on requester 1.
        req_len = 8'h30; tx_data = 16'h7700; req = 2'b10; step();
        chk("t4_sel", 32'(phy_sel), 32'd1);
        req = 2'b00; phy_bw = 1'b1; step(); phy_bw = 1'b0;
        phy_bv = 1'b1; phy_bo = 8'h77; step(); phy_bv = 1'b0;
        chk("t4_rxv", 32'(rx_valid), 32'd2);
`ifdef SPI_ARB_TIMEOUT_EN
        repeat (31) step();
        chk("t4_pre_err", 32'(err), 32'd0);
        chk("t4_pre_en", 32'(phy_enable), 32'd1);
        step();
        chk("t4_err", 32'(err), 32'd2);
        chk("t4_err_en", 32'(phy_enable), 32'd0);
        chk("t4_err_nodone", 32'(done), 32'd0);
        chk("t4_err_busy", 32'(busy), 32'd1);
        step();
        chk("t4_err_pulse", 32'(err), 32'd0);
        step();
        chk("t4_idle", 32'(busy), 32'd0);
`else
        repeat (40) step();
        chk("t4_stuck_busy", 32'(busy), 32'd1);
        chk("t4_stuck_en", 32'(phy_enable), 32'd1);
        chk("t4_no_err", 32'(err), 32'd0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t4_rst_busy", 32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters sharing one spi_phy.
REQ-002 SHALL have parameter LEN_W, default 4, width of per-requester byte-count field.
REQ-003 SHALL have parameter GAP_CYCLES, default 2, idle cycles with phy_enable low between transactions.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only when SPI_ARB_TIMEOUT_EN is defined).
REQ-005 SHALL have ports: clk_in in 1, sole clock, all logic on rising edge; reset in 1, synchronous, active-high.
REQ-006 SHALL have: req in N_REQ, per-requester transaction request; req_len in N_REQ*LEN_W, byte count, 0 means 2^LEN_W; tx_data in N_REQ*8, current tx byte per requester.
REQ-007 SHALL have: tx_ack out N_REQ, 1-cycle pulse when that requester's tx_data byte is taken; rx_data out 8, received byte; rx_valid out N_REQ, 1-cycle pulse qualifying rx_data.
REQ-008 SHALL have: done out N_REQ, 1-cycle end-of-transaction pulse; err out N_REQ, 1-cycle timeout pulse; busy out 1, high when not IDLE.
REQ-009 SHALL have: phy_enable out 1; phy_byte_in out 8; phy_sel out max(1,clog2(N_REQ)), slave index; phy_byte_written in 1; phy_byte_out in 8; phy_byte_valid in 1.

Function
REQ-010 SHALL implement FSM IDLE -> XFER -> DRAIN -> GAP -> IDLE.
REQ-011 IDLE: when any req bit is high at an edge, SHALL grant round-robin starting at index after last granted; at next edge enter XFER with phy_sel=winner, phy_enable=1, phy_byte_in=winner's tx_data, tx_ack[winner] pulsed that cycle (1-cycle request-to-enable latency).
REQ-012 SHALL capture req_len at grant; later req/req_len changes SHALL NOT affect the running transaction; deasserting req mid-transaction SHALL NOT abort it.
REQ-013 XFER: keep counter sent (=1 after grant); on phy_byte_written with sent<len, next edge SHALL load tx_data into phy_byte_in, pulse tx_ack, increment sent.
REQ-014 XFER: on phy_byte_written with sent==len, next edge SHALL drive phy_enable=0 and enter DRAIN; phy completes the in-flight byte.
REQ-015 In XFER or DRAIN each phy_byte_valid SHALL, next edge, register phy_byte_out to rx_data, pulse rx_valid[granted], increment rcvd.
REQ-016 When rcvd reaches len SHALL pulse done[granted] and enter GAP; phy_enable SHALL be 0 in GAP for exactly GAP_CYCLES cycles, then IDLE.
REQ-017 Counters SHALL be LEN_W+1 bits so len=2^LEN_W is exact; no wrap.
REQ-018 Simultaneous phy_byte_written and phy_byte_valid in one cycle SHALL both be serviced.
REQ-019 phy_byte_written/phy_byte_valid in IDLE or GAP SHALL be ignored.
REQ-020 At most one bit of tx_ack, rx_valid, done, err SHALL be high in any cycle.

Reset
REQ-021 While reset high at an edge: state=IDLE, all outputs 0, rx_data=0, phy_byte_in=0, phy_sel=0, counters 0, round-robin pointer so index 0 wins first.
REQ-022 Reset mid-transaction SHALL abort immediately with no done/err pulse.

Configuration
REQ-023 Macro SPI_ARB_TIMEOUT_EN defined: watchdog counts cycles in XFER/DRAIN without phy_byte_written or phy_byte_valid; at TIMEOUT_CYCLES SHALL drop phy_enable, pulse err[granted], no done, enter GAP.
REQ-024 Macro undefined: no watchdog logic; err SHALL be constant 0.

Structure
REQ-025 Shared package/include spi_pkg SHALL hold FSM state encodings and SEL width function; parameter defaults stay in module.
REQ-026 Sub-module spi_rr_arbiter (N_REQ round-robin, req+pointer -> one-hot grant) SHALL be used for arbitration.

Verification
REQ-027 Single req[0], len=3, tx 0x55,0xAA,0x0F, phy echo model -> three tx_ack[0], phy bytes 0x55,0xAA,0x0F, rx_valid[0]x3, done[0] once, then 2 gap cycles.
REQ-028 req=2'b11 held from reset -> grants 0,1,0,1 alternating; phy_sel follows; never two active.
REQ-029 len=0 -> exactly 16 bytes transferred, done after 16th rx_valid.
REQ-030 reset asserted in XFER after byte 2 of 4 -> next cycle all outputs 0, no done; new req then starts normally at index 0.
REQ-031 With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=32, phy stalls after byte 1 -> err pulse at cycle 32, phy_enable 0, no done; without macro -> busy stays high.
REQ-032 phy_byte_written and phy_byte_valid same cycle, len=2 -> both serviced, done after 2nd rx_valid.
